// File: rtl/nv_ram_rws_fifo_ctrl_128x256.sv
// FIFO controller driving an external 128x256 registered-read-address two-port RAM; the RAM dout is the output register.
// Latency: 2 cycles from input handshake to out_pvld on an empty FIFO; one pop per cycle sustained.
// Backpressure: in_prdy drops at 128 entries (registered state only); out_pd is held while out_pvld & ~out_prdy.
// Optional occupancy output enabled by defining NV_RAM_RWS_FIFO_COUNT_EN.
module nv_ram_rws_fifo_ctrl_128x256 (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_pvld,
    output logic         in_prdy,
    input  logic [255:0] in_pd,
    output logic         out_pvld,
    input  logic         out_prdy,
    output logic [255:0] out_pd,
    output logic         ram_we,
    output logic [6:0]   ram_wa,
    output logic [255:0] ram_di,
    output logic         ram_re,
    output logic [6:0]   ram_ra,
    input  logic [255:0] ram_dout,
    output logic [7:0]   fifo_count
);

    logic [7:0] wr_ptr_q, wr_ptr_d;
    logic [7:0] rd_ptr_q, rd_ptr_d;
    logic       out_vld_q, out_vld_d;
    logic [7:0] unread;
    logic [7:0] count;
    logic       push;
    logic       pop;

    always_comb begin
        unread   = wr_ptr_q - rd_ptr_q;
        // Displayed entry stays counted until popped, so its RAM slot is never overwritten.
        count    = unread + {7'd0, out_vld_q};
        in_prdy  = ~reset & (count != 8'd128);
        out_pvld = out_vld_q & ~reset;
        push     = in_pvld & in_prdy;
        pop      = out_pvld & out_prdy;
        ram_re   = ~reset & (unread != 8'd0) & (~out_vld_q | pop);

        ram_we   = push;
        ram_wa   = wr_ptr_q[6:0];
        ram_di   = in_pd;
        ram_ra   = rd_ptr_q[6:0];
        out_pd   = ram_dout;

        wr_ptr_d  = wr_ptr_q + {7'd0, push};
        rd_ptr_d  = rd_ptr_q + {7'd0, ram_re};
        out_vld_d = out_vld_q;
        if (ram_re) begin
            out_vld_d = 1'b1;
        end else if (pop) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= 8'd0;
            rd_ptr_q  <= 8'd0;
            out_vld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            out_vld_q <= out_vld_d;
        end
    end

`ifdef NV_RAM_RWS_FIFO_COUNT_EN
    assign fifo_count = reset ? 8'd0 : count;
`else
    assign fifo_count = 8'd0;
`endif

endmodule

// File: tb/tb_nv_ram_rws_fifo_ctrl_128x256.sv
// Bench for nv_ram_rws_fifo_ctrl_128x256: behavioural RAM beside the DUT and a timestamped queue reference model.
module tb_nv_ram_rws_fifo_ctrl_128x256;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_pvld;
    logic         in_prdy;
    logic [255:0] in_pd;
    logic         out_pvld;
    logic         out_prdy;
    logic [255:0] out_pd;
    logic         ram_we;
    logic [6:0]   ram_wa;
    logic [255:0] ram_di;
    logic         ram_re;
    logic [6:0]   ram_ra;
    logic [255:0] ram_dout;
    logic [7:0]   fifo_count;

    always #5 clk = ~clk;

    nv_ram_rws_fifo_ctrl_128x256 dut (
        .clk        (clk),
        .reset      (reset),
        .in_pvld    (in_pvld),
        .in_prdy    (in_prdy),
        .in_pd      (in_pd),
        .out_pvld   (out_pvld),
        .out_prdy   (out_prdy),
        .out_pd     (out_pd),
        .ram_we     (ram_we),
        .ram_wa     (ram_wa),
        .ram_di     (ram_di),
        .ram_re     (ram_re),
        .ram_ra     (ram_ra),
        .ram_dout   (ram_dout),
        .fifo_count (fifo_count)
    );

    // Two-port RAM with registered read address; dout holds while ram_re is low.
    logic [255:0] mem [0:127];
    logic [6:0]   ra_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    // Reference: every entry not yet popped, with the edge at which it was pushed.
    typedef struct {
        logic [255:0] d;
        int           t;
    } ent_t;
    ent_t q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int wcnt   = 0;
    int rcnt   = 0;
    int npop   = 0;
    logic         stall_prev = 1'b0;
    logic [255:0] pd_prev    = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic ivld, input logic [255:0] ipd, input logic ordy);
        logic prdy_e, vld_e, push, pop, re_e;
        int   disp, cnt_e;
        reset    = rst;
        in_pvld  = ivld;
        in_pd    = ipd;
        out_prdy = ordy;
        #1;
        // An entry pushed at edge E can be presented no earlier than the cycle after edge E+1.
        disp   = (q.size() > 0 && q[0].t < cyc) ? 1 : 0;
        prdy_e = !rst && (q.size() != 128);
        vld_e  = !rst && (disp == 1);
        push   = ivld && prdy_e;
        pop    = ordy && vld_e;
        re_e   = !rst && ((q.size() - disp) > 0) && (disp == 0 || pop);
        cnt_e  = rst ? 0 : q.size();
        chk("in_prdy",  256'(in_prdy),  256'(prdy_e));
        chk("out_pvld", 256'(out_pvld), 256'(vld_e));
        chk("ram_we",   256'(ram_we),   256'(push));
        chk("ram_re",   256'(ram_re),   256'(re_e));
`ifdef NV_RAM_RWS_FIFO_COUNT_EN
        chk("fifo_count", 256'(fifo_count), 256'(cnt_e));
`else
        chk("fifo_count_tied", 256'(fifo_count), 256'(0));
`endif
        if (push) begin
            chk("ram_wa", 256'(ram_wa), 256'(wcnt % 128));
            chk("ram_di", ram_di, ipd);
        end
        if (re_e) chk("ram_ra", 256'(ram_ra), 256'(rcnt % 128));
        if (vld_e) chk("out_pd", out_pd, q[0].d);
        if (stall_prev && vld_e) chk("pd_hold", out_pd, pd_prev);
        stall_prev = vld_e && !ordy;
        pd_prev    = out_pd;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            wcnt = 0;
            rcnt = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                npop++;
            end
            if (push) q.push_back('{d: ipd, t: cyc});
            if (push) wcnt++;
            if (re_e) rcnt++;
        end
        @(negedge clk);
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drain();
        for (int i = 0; i < 400 && q.size() > 0; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("drain_empty", 256'(q.size()), 256'(0));
    endtask

    initial begin
        logic [255:0] a5;
        int base;
        reset    = 1'b1;
        in_pvld  = 1'b0;
        in_pd    = '0;
        out_prdy = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, rnd256(), 1'b1);

        // Single entry
        a5 = {32{8'hA5}};
        cycle(1'b0, 1'b1, a5, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("single_popped", 256'(npop), 256'(1));

        // Fill to 128 with the consumer stalled
        for (int i = 0; i < 128; i++) cycle(1'b0, 1'b1, 256'(i + 1000), 1'b0);
        chk("full_prdy", 256'(in_prdy), 256'(0));
`ifdef NV_RAM_RWS_FIFO_COUNT_EN
        chk("full_count", 256'(fifo_count), 256'(128));
`endif
        cycle(1'b0, 1'b1, rnd256(), 1'b0);
        cycle(1'b0, 1'b1, rnd256(), 1'b1);
        chk("after_pop_prdy", 256'(in_prdy), 256'(1));
        cycle(1'b0, 1'b1, 256'(5555), 1'b0);
        chk("wrap_entry_q", 256'(q.size()), 256'(128));
        drain();

        // Streaming from empty: 300 cycles, first pop after 2 cycles, then no bubbles
        base = npop;
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 256'(32'h1000_0000 + i), 1'b1);
        chk("stream_pops", 256'(npop - base), 256'(298));
        drain();

        // Random backpressure until 1000 items have been popped
        base = npop;
        for (int i = 0; i < 6000 && (npop - base) < 1000; i++)
            cycle(1'b0, ($urandom_range(0, 3) != 0), rnd256(), $urandom_range(0, 1) == 1);
        chk("bp_items", 256'((npop - base) >= 1000), 256'(1));
        drain();

        // Reset with 40 entries queued
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, rnd256(), 1'b0);
        chk("pre_rst_q", 256'(q.size()), 256'(40));
        cycle(1'b1, 1'b1, rnd256(), 1'b0);
        reset   = 1'b0;
        in_pvld = 1'b0;
        #1;
        chk("post_rst_ovld", 256'(out_pvld), 256'(0));
        chk("post_rst_prdy", 256'(in_prdy), 256'(1));
`ifdef NV_RAM_RWS_FIFO_COUNT_EN
        chk("post_rst_count", 256'(fifo_count), 256'(0));
`endif
        base = npop;
        cycle(1'b0, 1'b1, {8{32'hC0FFEE00}}, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("post_rst_wait", 256'(npop - base), 256'(0));
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("post_rst_out", 256'(npop - base), 256'(1));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
